// File: rtl/win_gen_pkg.sv
// Shared constants and types for the 3x3 streaming window generator.
package win_gen_pkg;

  // Border handling modes selected per frame
  localparam logic PAD_ZERO = 1'b0;
  localparam logic PAD_REPL = 1'b1;

  // Number of taps in a 3x3 window
  localparam int unsigned WIN_TAPS = 9;

  // Row-major slot indices within the window
  localparam int unsigned SLOT_TL = 0;
  localparam int unsigned SLOT_TC = 1;
  localparam int unsigned SLOT_TR = 2;
  localparam int unsigned SLOT_ML = 3;
  localparam int unsigned SLOT_MC = 4;
  localparam int unsigned SLOT_MR = 5;
  localparam int unsigned SLOT_BL = 6;
  localparam int unsigned SLOT_BC = 7;
  localparam int unsigned SLOT_BR = 8;

  typedef enum logic {
    FILL,
    FLUSH
  } state_t;

  // Slot index from window-relative row/column (each 0..2)
  function automatic int unsigned slot_idx(input int unsigned row, input int unsigned col);
    return row * 3 + col;
  endfunction

endpackage

// File: rtl/window_gen_3x3_stream_line_buffer.sv
// One image row of delay: circular buffer of DEPTH pixels. The read is
// combinational from the slot about to be overwritten, so dout is the pixel
// written exactly DEPTH shifts earlier.
module line_buffer
  import win_gen_pkg::*;
#(
  parameter int unsigned DEPTH  = 256,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              shift_en,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;

  assign dout = mem[ptr];

  // Pointer advances once per shift and wraps at DEPTH-1
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (shift_en) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    end
  end

  // Storage write; contents are never cleared because stale data is masked downstream
  always_ff @(posedge clk) begin
    if (shift_en) begin
      mem[ptr] <= din;
    end
  end

endmodule

// File: rtl/window_gen_3x3_stream.sv
// Streaming 3x3 neighbourhood generator with two line buffers, per-frame
// border mode (zero pad / edge replicate), backpressure and end-of-frame flush.
module window_gen_3x3_stream
  import win_gen_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned IMG_W  = 256,
  parameter int unsigned IMG_H  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_pad_mode,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_W-1:0]          in_pixel,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [9*DATA_W-1:0]        out_win,
  output logic [$clog2(IMG_H)-1:0]   out_row,
  output logic [$clog2(IMG_W)-1:0]   out_col,
  output logic                       out_eof
);

  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);

  state_t            state;
  logic              pad_mode;
  logic [RW-1:0]     in_row;
  logic [CW-1:0]     in_col;
  logic [RW-1:0]     ctr_row;
  logic [CW-1:0]     ctr_col;

  logic [DATA_W-1:0] bot1, bot2, mid1, mid2, top1, top2;
  logic [DATA_W-1:0] lb1_out, lb2_out, new_pix;
  logic [DATA_W-1:0] raw [WIN_TAPS];
  logic [9*DATA_W-1:0] win_next;

  logic primed, in_last, in_fire, flush_step, step, load;

  // A window is due once the incoming pixel index reaches IMG_W+1
  assign primed  = (int'(in_row) >= 2) || ((in_row == RW'(1)) && (in_col != '0));
  assign in_last = (in_row == ROW_LAST) && (in_col == COL_LAST);

  assign in_ready   = (state == FILL) && (!out_valid || out_ready || !primed);
  assign in_fire    = in_valid && in_ready;
  // Flush steps stop once the final window sits in the output register
  assign flush_step = (state == FLUSH) && !(out_valid && out_eof) && (!out_valid || out_ready);
  assign step       = in_fire || flush_step;
  assign load       = flush_step || (in_fire && primed);

  // During flush a dummy pixel is shifted in; it only ever lands in masked slots
  assign new_pix = (state == FILL) ? in_pixel : '0;

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_mid (
    .clk      (clk),
    .rst      (rst),
    .shift_en (step),
    .din      (new_pix),
    .dout     (lb1_out)
  );

  line_buffer #(.DEPTH(IMG_W), .DATA_W(DATA_W)) u_lb_top (
    .clk      (clk),
    .rst      (rst),
    .shift_en (step),
    .din      (lb1_out),
    .dout     (lb2_out)
  );

  // Horizontal tap registers for each of the three rows
  always_ff @(posedge clk) begin
    if (step) begin
      bot1 <= new_pix;
      bot2 <= bot1;
      mid1 <= lb1_out;
      mid2 <= mid1;
      top1 <= lb2_out;
      top2 <= top1;
    end
  end

  // Raw neighbourhood around the centre being emitted (newest pixel is bottom-right)
  always_comb begin
    raw[SLOT_TL] = top2;
    raw[SLOT_TC] = top1;
    raw[SLOT_TR] = lb2_out;
    raw[SLOT_ML] = mid2;
    raw[SLOT_MC] = mid1;
    raw[SLOT_MR] = lb1_out;
    raw[SLOT_BL] = bot2;
    raw[SLOT_BC] = bot1;
    raw[SLOT_BR] = new_pix;
  end

  // Border masking: out-of-image slots become zero or fold onto the centre row/column
  always_comb begin
    logic top_oob, bot_oob, left_oob, right_oob;
    top_oob   = (ctr_row == '0);
    bot_oob   = (ctr_row == ROW_LAST);
    left_oob  = (ctr_col == '0);
    right_oob = (ctr_col == COL_LAST);
    win_next  = '0;
    for (int unsigned k = 0; k < WIN_TAPS; k++) begin
      int unsigned rr, cc;
      logic r_oob, c_oob;
      rr    = k / 3;
      cc    = k % 3;
      r_oob = ((rr == 0) && top_oob) || ((rr == 2) && bot_oob);
      c_oob = ((cc == 0) && left_oob) || ((cc == 2) && right_oob);
      if ((r_oob || c_oob) && (pad_mode != PAD_REPL)) begin
        win_next[k*DATA_W +: DATA_W] = '0;
      end else begin
        win_next[k*DATA_W +: DATA_W] = raw[slot_idx(r_oob ? 1 : rr, c_oob ? 1 : cc)];
      end
    end
  end

  // FSM, counters and the single output register
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FILL;
      pad_mode  <= PAD_ZERO;
      in_row    <= '0;
      in_col    <= '0;
      ctr_row   <= '0;
      ctr_col   <= '0;
      out_valid <= 1'b0;
      out_win   <= '0;
      out_row   <= '0;
      out_col   <= '0;
      out_eof   <= 1'b0;
    end else begin
      if (load) begin
        out_valid <= 1'b1;
        out_win   <= win_next;
        out_row   <= ctr_row;
        out_col   <= ctr_col;
        out_eof   <= (ctr_row == ROW_LAST) && (ctr_col == COL_LAST);
        if (ctr_col == COL_LAST) begin
          ctr_col <= '0;
          ctr_row <= (ctr_row == ROW_LAST) ? '0 : ctr_row + 1'b1;
        end else begin
          ctr_col <= ctr_col + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (in_fire) begin
        if ((in_row == '0) && (in_col == '0)) begin
          pad_mode <= cfg_pad_mode;
        end
        if (in_col == COL_LAST) begin
          in_col <= '0;
          in_row <= (in_row == ROW_LAST) ? '0 : in_row + 1'b1;
        end else begin
          in_col <= in_col + 1'b1;
        end
        if (in_last) begin
          state <= FLUSH;
        end
      end

      if ((state == FLUSH) && out_valid && out_eof && out_ready) begin
        state <= FILL;
      end
    end
  end

endmodule
